// File: rtl/ascon_sequencer.sv
// Command sequencer for an Ascon AEAD/hash core: steps through init, AD absorption,
// message encrypt/decrypt, squeeze and finalization, handshaking 128-bit blocks with the host.
module ascon_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   cmd,
    input  logic [31:0]  ad_len,
    input  logic [31:0]  msg_len,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic [127:0] tag_in,
    output logic         busy,
    output logic         done,
    output logic         tag_ok,
    output logic [127:0] tag_out,
    input  logic         abort,
    output logic         process_en_init,
    output logic         process_en_AE_AM,
    output logic         process_en_encrypt_decrypt,
    output logic         process_en_hash,
    output logic         process_en_final,
    output logic [1:0]   sel_type,
    output logic         mode_sel_encrypt_decrypt,
    output logic [31:0]  data_length,
    output logic [31:0]  data_position,
    output logic [127:0] core_data_in,
    input  logic [127:0] core_data_out,
    input  logic [127:0] core_tag
);

    typedef enum logic [2:0] {IDLE, INIT, AD, MSG, SQZ, FINAL, DONE} state_t;
    typedef enum logic [1:0] {PH_WAIT, PH_EN1, PH_EN2} phase_t;

    state_t state, state_next;
    phase_t phase, phase_next;
    state_t after_ad, after_init;

    logic [1:0]  cmd_q;
    logic [31:0] ad_len_q, msg_len_q;
    logic [27:0] ad_blocks, msg_blocks, blk_idx;
    logic [1:0]  sq_cnt;
    logic        is_hash, last_ad, last_msg;
    logic        accept, load_in, blk_clr, blk_inc, cap_msg, cap_sqz, cap_final;

    function automatic logic [27:0] block_count(input logic [31:0] len);
        return len[31:4] + {27'd0, |len[3:0]};
    endfunction

    // Empty phases are skipped by choosing the destination ahead of time.
    always_comb begin
        is_hash  = (cmd_q == 2'd2);
        last_ad  = (blk_idx + 28'd1 == ad_blocks);
        last_msg = (blk_idx + 28'd1 == msg_blocks);
        if (is_hash)
            after_ad = SQZ;
        else if (msg_blocks != '0)
            after_ad = MSG;
        else
            after_ad = FINAL;
        after_init = (ad_blocks != '0) ? AD : after_ad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            phase <= PH_WAIT;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    always_comb begin
        state_next                 = state;
        phase_next                 = phase;
        accept                     = 1'b0;
        load_in                    = 1'b0;
        blk_clr                    = 1'b0;
        blk_inc                    = 1'b0;
        cap_msg                    = 1'b0;
        cap_sqz                    = 1'b0;
        cap_final                  = 1'b0;
        in_ready                   = 1'b0;
        done                       = 1'b0;
        process_en_init            = 1'b0;
        process_en_AE_AM           = 1'b0;
        process_en_encrypt_decrypt = 1'b0;
        process_en_hash            = 1'b0;
        process_en_final           = 1'b0;
        mode_sel_encrypt_decrypt   = 1'b0;
        data_length                = '0;
        data_position              = '0;
        busy                       = (state != IDLE);
        sel_type                   = (state != IDLE && is_hash) ? 2'b01 : 2'b00;

        case (state)
            IDLE: begin
                if (start && cmd != 2'd3) begin
                    accept     = 1'b1;
                    state_next = INIT;
                end
            end
            INIT: begin
                process_en_init = 1'b1;
                blk_clr         = 1'b1;
                state_next      = after_init;
                phase_next      = (after_init == SQZ) ? PH_EN1 : PH_WAIT;
            end
            AD: begin
                data_length   = ad_len_q;
                data_position = {blk_idx, 4'b0000};
                case (phase)
                    PH_WAIT: begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load_in    = 1'b1;
                            phase_next = PH_EN1;
                        end
                    end
                    PH_EN1: begin
                        process_en_AE_AM = 1'b1;
                        phase_next       = PH_EN2;
                    end
                    default: begin
                        process_en_AE_AM = 1'b1;
                        if (last_ad) begin
                            blk_clr    = 1'b1;
                            state_next = after_ad;
                            phase_next = (after_ad == SQZ) ? PH_EN1 : PH_WAIT;
                        end else begin
                            blk_inc    = 1'b1;
                            phase_next = PH_WAIT;
                        end
                    end
                endcase
            end
            MSG: begin
                data_length              = msg_len_q;
                data_position            = {blk_idx, 4'b0000};
                mode_sel_encrypt_decrypt = cmd_q[0];
                case (phase)
                    PH_WAIT: begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load_in    = 1'b1;
                            phase_next = PH_EN1;
                        end
                    end
                    PH_EN1: begin
                        process_en_encrypt_decrypt = 1'b1;
                        phase_next                 = PH_EN2;
                    end
                    default: begin
                        process_en_encrypt_decrypt = 1'b1;
                        cap_msg                    = 1'b1;
                        phase_next                 = PH_WAIT;
                        if (last_msg) begin
                            blk_clr    = 1'b1;
                            state_next = FINAL;
                        end else begin
                            blk_inc = 1'b1;
                        end
                    end
                endcase
            end
            SQZ: begin
                process_en_hash = 1'b1;
                if (phase == PH_EN2) begin
                    cap_sqz = 1'b1;
                    if (sq_cnt == 2'd3)
                        state_next = DONE;
                    phase_next = PH_EN1;
                end else begin
                    phase_next = PH_EN2;
                end
            end
            FINAL: begin
                process_en_final = 1'b1;
                cap_final        = 1'b1;
                state_next       = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides everything, including a start in IDLE and a pending handshake.
        if (abort) begin
            state_next = IDLE;
            phase_next = PH_WAIT;
            in_ready   = 1'b0;
            accept     = 1'b0;
            load_in    = 1'b0;
            blk_inc    = 1'b0;
            blk_clr    = 1'b1;
            cap_msg    = 1'b0;
            cap_sqz    = 1'b0;
            cap_final  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            ad_len_q     <= '0;
            msg_len_q    <= '0;
            ad_blocks    <= '0;
            msg_blocks   <= '0;
            blk_idx      <= '0;
            sq_cnt       <= '0;
            core_data_in <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            tag_out      <= '0;
            tag_ok       <= 1'b0;
        end else begin
            out_valid <= cap_msg | cap_sqz;
            if (accept) begin
                cmd_q      <= cmd;
                ad_len_q   <= ad_len;
                msg_len_q  <= msg_len;
                ad_blocks  <= block_count(ad_len);
                msg_blocks <= block_count(msg_len);
                sq_cnt     <= '0;
                tag_out    <= '0;
                tag_ok     <= 1'b0;
            end
            if (blk_clr)
                blk_idx <= '0;
            else if (blk_inc)
                blk_idx <= blk_idx + 28'd1;
            if (load_in)
                core_data_in <= in_data;
            if (cap_msg)
                out_data <= core_data_out;
            if (cap_sqz) begin
                out_data <= {64'd0, core_data_out[63:0]};
                sq_cnt   <= sq_cnt + 2'd1;
            end
            if (cap_final) begin
                tag_out <= core_tag;
                tag_ok  <= (cmd_q == 2'd1) ? (core_tag == tag_in) : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ascon_sequencer.sv
// Self-checking bench for ascon_sequencer: table of whole transactions with hand-computed
// enable/output counts, plus directed sequences for stall, abort and mid-run reset.
module tb_ascon_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   cmd = '0;
    logic [31:0]  ad_len = '0, msg_len = '0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] tag_in = '0, core_tag = '0;
    logic         abort = 1'b0;
    logic [127:0] core_data_out;

    logic         in_ready, out_valid, busy, done, tag_ok;
    logic [127:0] out_data, tag_out, core_data_in;
    logic         process_en_init, process_en_AE_AM, process_en_encrypt_decrypt;
    logic         process_en_hash, process_en_final, mode_sel_encrypt_decrypt;
    logic [1:0]   sel_type;
    logic [31:0]  data_length, data_position;

    int checks = 0;
    int errors = 0;
    int n_out;

    localparam logic [127:0] XMASK = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    ascon_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .ad_len(ad_len), .msg_len(msg_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .tag_in(tag_in),
        .busy(busy), .done(done), .tag_ok(tag_ok), .tag_out(tag_out), .abort(abort),
        .process_en_init(process_en_init), .process_en_AE_AM(process_en_AE_AM),
        .process_en_encrypt_decrypt(process_en_encrypt_decrypt),
        .process_en_hash(process_en_hash), .process_en_final(process_en_final),
        .sel_type(sel_type), .mode_sel_encrypt_decrypt(mode_sel_encrypt_decrypt),
        .data_length(data_length), .data_position(data_position),
        .core_data_in(core_data_in), .core_data_out(core_data_out), .core_tag(core_tag)
    );

    always #5 clk = ~clk;

    // Core stand-in: squeezes return a count-tagged word with junk in the upper half.
    assign core_data_out = process_en_hash ? {64'hFEEDFACECAFEBEEF, 64'h5A5A0000 + 64'(n_out)}
                                           : (core_data_in ^ XMASK);

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] ad_len;
        logic [31:0] msg_len;
        bit          bad_tag;
        bit          stall;
        int          exp_ae;
        int          exp_ed;
        int          exp_hash;
        int          exp_final;
        int          exp_out;
        bit          exp_tag_ok;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [127:0] pattern(input int k);
        return {4{32'hC0DE0000 + 32'(k)}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {115'd0, busy, done, tag_ok, in_ready, out_valid, process_en_init,
              process_en_AE_AM, process_en_encrypt_decrypt, process_en_hash, process_en_final,
              sel_type, mode_sel_encrypt_decrypt}, '0);
        check({tag, "_len_pos"}, {64'd0, data_length, data_position}, '0);
        check({tag, "_core_data_in"}, core_data_in, '0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_tag_out"}, tag_out, '0);
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int  k, nad, n_init, n_ae, n_ed, n_hash, n_final, n_done, stall_left;
        int  pos_err, data_err, sel_err, onehot_err, stall_err;
        bit  hs_pend, hash, seen_done;
        logic [127:0] exp_o;
        k = 0; n_init = 0; n_ae = 0; n_ed = 0; n_hash = 0; n_final = 0; n_done = 0;
        pos_err = 0; data_err = 0; sel_err = 0; onehot_err = 0; stall_err = 0;
        stall_left = 0; hs_pend = 0; seen_done = 0; n_out = 0;
        hash     = (v.cmd == 2'd2);
        nad      = int'((v.ad_len + 32'd15) >> 4);
        core_tag = {4{32'h7A600000 + 32'(id)}};
        tag_in   = v.bad_tag ? (core_tag ^ 128'h1) : core_tag;
        in_data  = pattern(0);
        in_valid = 1'b1;
        @(negedge clk);
        cmd = v.cmd; ad_len = v.ad_len; msg_len = v.msg_len; start = 1'b1;
        for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (hs_pend) begin
                k++;
                in_data = pattern(k);
                hs_pend = 0;
                if (v.stall && k == 1) begin
                    in_valid   = 1'b0;
                    stall_left = 13;
                end
            end
            if (stall_left > 0) begin
                if (stall_left <= 11 && (!in_ready || process_en_AE_AM || process_en_encrypt_decrypt))
                    stall_err++;
                stall_left--;
                if (stall_left == 0) in_valid = 1'b1;
            end
            if (in_valid && in_ready) hs_pend = 1;
            if ($countones({process_en_init, process_en_AE_AM, process_en_encrypt_decrypt,
                            process_en_hash, process_en_final}) > 1) onehot_err++;
            if (busy && sel_type != (hash ? 2'b01 : 2'b00)) sel_err++;
            if (process_en_init) n_init++;
            if (process_en_AE_AM) begin
                if (data_position != 32'((n_ae / 2) * 16) || data_length != v.ad_len) pos_err++;
                if (core_data_in != pattern(n_ae / 2)) data_err++;
                n_ae++;
            end
            if (process_en_encrypt_decrypt) begin
                if (data_position != 32'((n_ed / 2) * 16) || data_length != v.msg_len ||
                    mode_sel_encrypt_decrypt != v.cmd[0]) pos_err++;
                if (core_data_in != pattern(nad + n_ed / 2)) data_err++;
                n_ed++;
            end
            if (process_en_hash) n_hash++;
            if (process_en_final) n_final++;
            if (out_valid) begin
                exp_o = hash ? {64'd0, 64'h5A5A0000 + 64'(n_out)} : (pattern(nad + n_out) ^ XMASK);
                if (out_data !== exp_o) begin
                    $display("FAIL out_data[%0d] txn %0d: got %0h, expected %0h", n_out, id, out_data, exp_o);
                    data_err++;
                end
                n_out++;
            end
            if (done) begin
                n_done++;
                seen_done = 1;
            end
        end
        check("done_seen", {127'd0, seen_done}, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_done", {126'd0, busy, done}, 0);
        check("n_init", n_init, 1);
        check("n_ae_am", n_ae, v.exp_ae);
        check("n_enc_dec", n_ed, v.exp_ed);
        check("n_hash", n_hash, v.exp_hash);
        check("n_final", n_final, v.exp_final);
        check("n_out_valid", n_out, v.exp_out);
        check("n_done", n_done, 1);
        check("tag_out", tag_out, hash ? 128'd0 : core_tag);
        check("tag_ok", {127'd0, tag_ok}, {127'd0, v.exp_tag_ok});
        check("pos_len_errors", pos_err, 0);
        check("data_errors", data_err, 0);
        check("sel_type_errors", sel_err, 0);
        check("onehot_errors", onehot_err, 0);
        if (v.stall) check("stall_errors", stall_err, 0);
    endtask

    initial begin
        int  run;
        bit  late_out;
        //          cmd    ad_len  msg_len bad stall ae ed  h  f  out ok
        vecs[0] = '{2'd0, 32'd16, 32'd32,  0,  0,   2, 4,  0, 1, 2,  1};
        vecs[1] = '{2'd1, 32'd0,  32'd5,   0,  0,   0, 2,  0, 1, 1,  1};
        vecs[2] = '{2'd1, 32'd0,  32'd5,   1,  0,   0, 2,  0, 1, 1,  0};
        vecs[3] = '{2'd2, 32'd17, 32'd0,   0,  0,   4, 0,  8, 0, 4,  0};
        vecs[4] = '{2'd0, 32'd33, 32'd0,   0,  0,   6, 0,  0, 1, 0,  1};
        vecs[5] = '{2'd2, 32'd0,  32'd100, 0,  0,   0, 0,  8, 0, 4,  0};
        vecs[6] = '{2'd1, 32'd15, 32'd48,  1,  0,   2, 6,  0, 1, 3,  0};
        vecs[7] = '{2'd0, 32'd32, 32'd16,  0,  1,   4, 2,  0, 1, 1,  1};

        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Reserved command is ignored.
        cmd = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cmd3_ignored", {126'd0, busy, process_en_init}, 0);

        // Abort beats start in IDLE.
        cmd = 2'd0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", {127'd0, busy}, 0);

        // Start while busy is ignored; abort in the second encrypt enable cycle.
        cmd = 2'd0; ad_len = 32'd0; msg_len = 32'd32; in_data = pattern(0); in_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_init", {127'd0, process_en_init}, 1);
        cmd = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", {125'd0, process_en_init, sel_type}, 0);
        run = 0;
        for (int c = 0; c < 20 && run < 2; c++) begin
            @(negedge clk);
            if (process_en_encrypt_decrypt) run++;
            else run = 0;
        end
        check("abort_window_found", run, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_next_cycle", {120'd0, process_en_init, process_en_AE_AM,
              process_en_encrypt_decrypt, process_en_hash, process_en_final,
              in_ready, out_valid, busy}, 0);
        check("abort_no_done", {127'd0, done}, 0);
        late_out = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid || busy) late_out = 1;
        end
        check("abort_stays_idle", {127'd0, late_out}, 0);

        // Reset asserted inside the AD enable window.
        cmd = 2'd0; ad_len = 32'd16; msg_len = 32'd32; in_data = pattern(0); in_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run = 0;
        for (int c = 0; c < 20 && run == 0; c++) begin
            @(negedge clk);
            if (process_en_AE_AM) run = 1;
        end
        check("rst_window_found", run, 1);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(vecs[0], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascon_sequencer.md
ASCON_SEQUENCER -- requirements
Module: ascon_sequencer

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset; one clock, no other reset.
REQ-003 start  in  1  command request, sampled only in IDLE.
REQ-004 cmd  in  2  operation: 0 encrypt, 1 decrypt, 2 hash, 3 reserved (start ignored).
REQ-005 ad_len, msg_len  in  32 each  byte counts, latched on accepted start.
REQ-006 in_valid  in  1 / in_data  in  128 / in_ready  out  1  host input block handshake.
REQ-007 out_valid  out  1 / out_data  out  128  result block, one-cycle pulse, no backpressure.
REQ-008 tag_in  in  128  expected tag for decrypt; sampled in FINAL.
REQ-009 busy, done, tag_ok  out  1 each; tag_out  out  128.
REQ-010 abort  in  1  synchronous cancel.
REQ-011 Core side, all out: process_en_init, process_en_AE_AM, process_en_encrypt_decrypt, process_en_hash, process_en_final (1 each); sel_type (2); mode_sel_encrypt_decrypt (1); data_length, data_position (32 each); core_data_in (128).
REQ-012 Core side, in: core_data_out (128), core_tag (128).

Function
REQ-013 States: IDLE, INIT, AD, MSG, SQZ, FINAL, DONE; at most one process_en_* high in any cycle.
REQ-014 IDLE: start=1 with cmd!=3 -> latch cmd/lengths, busy=1, go INIT; start with cmd=3 or outside IDLE ignored.
REQ-015 INIT: process_en_init=1 exactly one cycle; sel_type=00 (encrypt/decrypt) or 01 (hash), held constant until DONE.
REQ-016 Block count n = len[31:4] + (len[3:0]!=0), 28-bit counter; n=0 skips the phase in zero cycles.
REQ-017 AD phase (ad_len): in_ready=1 while waiting; in_valid&in_ready -> latch in_data to core_data_in, in_ready=0, process_en_AE_AM=1 for exactly 2 cycles, data_position=blk_idx*16, data_length=ad_len.
REQ-018 MSG phase (msg_len, cmd 0/1): same handshake; process_en_encrypt_decrypt=1 for 2 cycles; mode_sel_encrypt_decrypt=cmd[0]; on the second cycle capture core_data_out -> out_data, out_valid=1 next cycle.
REQ-019 Hash: AD phase absorbs ad_len bytes of message; MSG skipped; SQZ issues 4 squeezes, process_en_hash=1 for 2 cycles each, out_data={64'b0, core_data_out[63:0]} with out_valid after each.
REQ-020 FINAL (cmd 0/1): process_en_final=1 one cycle; tag_out<=core_tag; decrypt: tag_ok<=(core_tag==tag_in); encrypt: tag_ok<=1. Hash skips FINAL.
REQ-021 DONE: done=1 one cycle, busy=0 next cycle, return to IDLE; tag_out/tag_ok held until next accepted start.
REQ-022 Next block accepted no earlier than the cycle after the 2-cycle enable window; minimum 3 cycles/block.
REQ-023 in_valid outside AD/MSG wait: ignored, no in_ready.
REQ-024 abort=1 in any state: next cycle all process_en_* =0, in_ready=0, out_valid=0, state IDLE, busy=0, done not asserted; abort wins over start.
REQ-025 Partial final block passed as full 128 bits; padding/truncation is the core's via data_length/data_position.

Reset
REQ-026 rst_n=0: state IDLE; all outputs 0 (busy, done, tag_ok, in_ready, out_valid, every process_en_*, sel_type, mode_sel, data_length, data_position, core_data_in, out_data, tag_out); counters 0.
REQ-027 Reset mid-operation aborts immediately; after release, first start behaves as from power-up.

Verification
REQ-028 Encrypt, ad_len=16, msg_len=32: init 1 cycle, AE_AM 2 cycles pos 0, enc_dec 2 cycles pos 0 then 16, 2 out_valid pulses, final 1 cycle, done; tag_out=core_tag.
REQ-029 Decrypt, ad_len=0, msg_len=5: no AE_AM; one enc_dec block, data_length=5, mode_sel=1; tag_in==core_tag -> tag_ok=1; mismatched tag_in -> tag_ok=0.
REQ-030 Hash, ad_len=17: 2 AE_AM blocks (pos 0,16), 4 squeezes, 4 out_valid pulses, no process_en_final, sel_type=01.
REQ-031 in_valid low 10 cycles mid-AD: enables stay 0, in_ready stays 1, resume on in_valid.
REQ-032 abort during MSG second enable cycle -> next cycle all enables 0, IDLE, no out_valid; start during busy ignored.
REQ-033 rst_n low during AD enable window -> all outputs 0 asynchronously; new start runs REQ-028 correctly.
